fetch_unit: RTL and testbench

Instruction fetch stage of the single-cycle MIPS processor, sitting directly upstream of the `control` decoder. It owns the program counter and fetches one instruction word from a multi-cycle instruction memory through a req/ready handshake. It holds that word on `instruction` for decode until the execute side acknowledges it, then advances the PC. PC selection uses the decoder's `is_jump`, `is_branch`, `imm16` and `addr26` outputs, plus a branch-taken flag and a register target from execute.

---
 rtl/fetch_unit_pkg.sv | 18 +
 rtl/fetch_unit_next_pc.sv | 29 ++
 rtl/fetch_unit.sv | 104 ++++++++++
 tb/tb_fetch_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared state encodings, reset PC and branch-offset helper for the fetch stage.
// Optional feature macro used by fetch_unit: FETCH_STALL_COUNT_EN.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_FETCH = 2'd1,
    FETCH_HOLD  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Word offset to byte offset, sign-extended to 32 bits.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_next_pc.sv
// Combinational next-PC selection (module fetch_next_pc): register jump, absolute
// jump, taken branch, then sequential; all arithmetic wraps modulo 2^32.
module fetch_next_pc
  import fetch_unit_pkg::*;
(
  input  logic        is_jump_reg,
  input  logic        is_jump,
  input  logic        is_branch,
  input  logic        branch_taken,
  input  logic [31:0] reg_target,
  input  logic [15:0] imm16,
  input  logic [25:0] addr26,
  input  logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  always_comb begin
    next_pc = pc_plus4;
    if (is_jump_reg) begin
      // jr targets are forced word-aligned rather than trapping.
      next_pc = {reg_target[31:2], 2'b00};
    end else if (is_jump) begin
      next_pc = {pc_plus4[31:28], addr26, 2'b00};
    end else if (is_branch && branch_taken) begin
      next_pc = pc_plus4 + branch_offset(imm16);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word per req/ready handshake
// and holds it until acknowledged. Define FETCH_STALL_COUNT_EN to add stall_count.
//
// state       | meaning
// FETCH_IDLE  | out of reset, no request yet
// FETCH_FETCH | imem_req high, waiting for imem_ready
// FETCH_HOLD  | instruction valid, waiting for instr_ack
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] instruction,
  output logic        instr_valid,
  input  logic        instr_ack,
  input  logic        is_jump,
  input  logic        is_branch,
  input  logic        branch_taken,
  input  logic        is_jump_reg,
  input  logic [31:0] reg_target,
  input  logic [15:0] imm16,
  input  logic [25:0] addr26,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
`ifdef FETCH_STALL_COUNT_EN
  ,
  output logic [31:0] stall_count
`endif
);

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic         capture;
  logic         advance;
  logic [31:0]  next_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH_IDLE:  state_d = FETCH_FETCH;
      FETCH_FETCH: if (imem_ready) state_d = FETCH_HOLD;
      FETCH_HOLD:  if (instr_ack) state_d = FETCH_FETCH;
      default:     state_d = FETCH_IDLE;
    endcase
  end

  // ready and ack only matter in the state that waits for them.
  always_comb begin
    imem_req    = (state_q == FETCH_FETCH);
    instr_valid = (state_q == FETCH_HOLD);
    capture     = imem_req && imem_ready;
    advance     = instr_valid && instr_ack;
  end

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  fetch_next_pc u_next_pc (
    .is_jump_reg  (is_jump_reg),
    .is_jump      (is_jump),
    .is_branch    (is_branch),
    .branch_taken (branch_taken),
    .reg_target   (reg_target),
    .imm16        (imm16),
    .addr26       (addr26),
    .pc_plus4     (pc_plus4),
    .next_pc      (next_pc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      instruction <= 32'd0;
    end else begin
      if (advance) pc <= next_pc;
      if (capture) instruction <= imem_rdata;
    end
  end

`ifdef FETCH_STALL_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_count <= 32'd0;
    end else if (imem_req && !imem_ready && (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed sequences, a next-PC vector table
// and a randomized run against a cycle-level reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        instr_ack;
  logic        is_jump, is_branch, branch_taken, is_jump_reg;
  logic [31:0] reg_target;
  logic [15:0] imm16;
  logic [25:0] addr26;
  logic [31:0] pc, pc_plus4;
`ifdef FETCH_STALL_COUNT_EN
  logic [31:0] stall_count;
`endif

  logic        use_fn;
  logic [31:0] rdata_fixed;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0FF_EE00;
  endfunction

  assign imem_rdata = use_fn ? mem_fn(imem_addr) : rdata_fixed;

  fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ready   (imem_ready),
    .instruction  (instruction),
    .instr_valid  (instr_valid),
    .instr_ack    (instr_ack),
    .is_jump      (is_jump),
    .is_branch    (is_branch),
    .branch_taken (branch_taken),
    .is_jump_reg  (is_jump_reg),
    .reg_target   (reg_target),
    .imm16        (imm16),
    .addr26       (addr26),
    .pc           (pc),
    .pc_plus4     (pc_plus4)
`ifdef FETCH_STALL_COUNT_EN
    ,
    .stall_count  (stall_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sel();
    is_jump = 0; is_branch = 0; branch_taken = 0; is_jump_reg = 0;
    reg_target = 0; imm16 = 0; addr26 = 0;
  endtask

  // Reference next PC written straight from the selection rules.
  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic jr, input logic j,
                                           input logic br, input logic tk, input logic [31:0] rt,
                                           input logic [15:0] im, input logic [25:0] a26);
    logic [31:0] seq;
    int off;
    seq = p + 32'd4;
    off = $signed(im);
    if (jr) return rt - (rt % 4);
    if (j) return (seq & 32'hF000_0000) | ({6'd0, a26} * 4);
    if (br && tk) return seq + 32'(off * 4);
    return seq;
  endfunction

  typedef struct {
    logic [31:0] start_pc;
    logic        jr, j, br, tk;
    logic [31:0] rt;
    logic [15:0] im;
    logic [25:0] a26;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[9];

  // From HOLD: redirect via jr, then complete a fetch so the DUT holds start_pc.
  task automatic goto_pc(input logic [31:0] a);
    is_jump_reg = 1; reg_target = a; instr_ack = 1;
    tick();
    clear_sel(); instr_ack = 0; imem_ready = 1;
    tick();
    imem_ready = 0;
    chk("goto_pc", pc, a);
    chk("goto_valid", {31'd0, instr_valid}, 32'd1);
  endtask

  logic        m_started, m_hold;
  logic [31:0] m_pc, m_instr, m_stall;
  logic [31:0] held_instr, held_pc;

  initial begin
    rst_n = 0; imem_ready = 0; instr_ack = 0; use_fn = 1; rdata_fixed = 0;
    clear_sel();

    vecs[0] = '{32'h0000_0100, 0, 0, 1, 1, 32'h0, 16'hFFFD, 26'h0, 32'h0000_00F8};
    vecs[1] = '{32'h0000_0100, 0, 0, 1, 0, 32'h0, 16'hFFFD, 26'h0, 32'h0000_0104};
    vecs[2] = '{32'h1000_0000, 0, 1, 0, 0, 32'h0, 16'h0, 26'h0000040, 32'h1000_0100};
    vecs[3] = '{32'h0000_0040, 1, 1, 0, 0, 32'h0000_0203, 16'h0, 26'h0000040, 32'h0000_0200};
    vecs[4] = '{32'h0000_0300, 0, 0, 0, 1, 32'h0, 16'h0010, 26'h0, 32'h0000_0304};
    vecs[5] = '{32'hFFFF_FFFC, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0000_0000};
    vecs[6] = '{32'hFFFF_FFFC, 0, 1, 0, 0, 32'h0, 16'h0, 26'h3FF_FFFF, 32'h0FFF_FFFC};
    vecs[7] = '{32'h0000_0200, 0, 0, 1, 1, 32'h0, 16'h0010, 26'h0, 32'h0000_0244};
    vecs[8] = '{32'hFFFF_FFF8, 0, 0, 1, 1, 32'h0, 16'h0001, 26'h0, 32'h0000_0000};

    // Reset state
    tick(); tick();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instruction, 32'd0);
    chk("rst_pc", pc, 32'd0);
`ifdef FETCH_STALL_COUNT_EN
    chk("rst_stall", stall_count, 32'd0);
`endif

    // Zero-wait memory, ack tied high: one instruction every two cycles
    rst_n = 1; imem_ready = 1; instr_ack = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("stream_valid", {31'd0, instr_valid}, (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("stream_req", {31'd0, imem_req}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("stream_addr", imem_addr, 32'(4 * (i / 2)));
      if (i % 2 == 1) chk("stream_instr", instruction, mem_fn(32'(4 * (i / 2))));
    end
    imem_ready = 0; instr_ack = 0;

    // Three wait states, addi word
    rst_n = 0; tick();
    rst_n = 1; use_fn = 0; rdata_fixed = 32'h2010_FEFE; tick();
    for (int i = 0; i < 3; i++) begin
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      chk("wait_valid", {31'd0, instr_valid}, 32'd0);
      tick();
    end
    imem_ready = 1; tick(); imem_ready = 0;
    chk("wait_valid_rise", {31'd0, instr_valid}, 32'd1);
    chk("wait_instr", instruction, 32'h2010_FEFE);
`ifdef FETCH_STALL_COUNT_EN
    chk("wait_stall", stall_count, 32'd3);
`endif

    // Stalled ack: instruction and pc frozen, ready ignored while holding
    held_instr = instruction; held_pc = pc;
    rdata_fixed = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      imem_ready = i[0];
      tick();
      chk("hold_instr", instruction, held_instr);
      chk("hold_pc", pc, held_pc);
      chk("hold_req", {31'd0, imem_req}, 32'd0);
      chk("hold_valid", {31'd0, instr_valid}, 32'd1);
    end
    imem_ready = 0; use_fn = 1;

    // Next-PC vector table
    foreach (vecs[k]) begin
      goto_pc(vecs[k].start_pc);
      is_jump_reg = vecs[k].jr; is_jump = vecs[k].j; is_branch = vecs[k].br;
      branch_taken = vecs[k].tk; reg_target = vecs[k].rt; imm16 = vecs[k].im;
      addr26 = vecs[k].a26; instr_ack = 1;
      tick();
      clear_sel(); instr_ack = 0;
      chk("vec_addr", imem_addr, vecs[k].exp_addr);
      chk("vec_req", {31'd0, imem_req}, 32'd1);
      if (k != 8) begin
        imem_ready = 1; tick(); imem_ready = 0;
      end
    end

    // Reset while fetching
    tick();
    chk("midfetch_req_before", {31'd0, imem_req}, 32'd1);
    rst_n = 0; imem_ready = 1; tick();
    chk("midfetch_pc", pc, 32'd0);
    chk("midfetch_req", {31'd0, imem_req}, 32'd0);
    chk("midfetch_valid", {31'd0, instr_valid}, 32'd0);
    rst_n = 1; imem_ready = 0; tick();
    chk("refetch_req", {31'd0, imem_req}, 32'd1);
    chk("refetch_addr", imem_addr, 32'd0);

    // Randomized run against the reference model
    rst_n = 0; tick();
    m_started = 0; m_hold = 0; m_pc = 0; m_instr = 0; m_stall = 0;
    for (int c = 0; c < 800; c++) begin
      rst_n        = ($urandom_range(0, 59) != 0);
      imem_ready   = ($urandom_range(0, 2) == 0);
      instr_ack    = ($urandom_range(0, 1) == 0);
      is_jump_reg  = ($urandom_range(0, 7) == 0);
      is_jump      = ($urandom_range(0, 5) == 0);
      is_branch    = $urandom_range(0, 1);
      branch_taken = $urandom_range(0, 1);
      reg_target   = $urandom;
      imm16        = 16'($urandom);
      addr26       = 26'($urandom);
      if (!rst_n) begin
        m_started = 0; m_hold = 0; m_pc = 0; m_instr = 0; m_stall = 0;
      end else if (!m_started) begin
        m_started = 1;
      end else if (!m_hold) begin
        if (imem_ready) begin
          m_instr = mem_fn(m_pc); m_hold = 1;
        end else if (m_stall != 32'hFFFF_FFFF) begin
          m_stall = m_stall + 1;
        end
      end else if (instr_ack) begin
        m_pc = ref_next(m_pc, is_jump_reg, is_jump, is_branch, branch_taken,
                        reg_target, imm16, addr26);
        m_hold = 0;
      end
      tick();
      chk("rnd_pc", pc, m_pc);
      chk("rnd_pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("rnd_addr", imem_addr, m_pc);
      chk("rnd_req", {31'd0, imem_req}, {31'd0, m_started && !m_hold});
      chk("rnd_valid", {31'd0, instr_valid}, {31'd0, m_hold});
      chk("rnd_instr", instruction, m_instr);
`ifdef FETCH_STALL_COUNT_EN
      chk("rnd_stall", stall_count, m_stall);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
